// File: rtl/button_conditioner.sv
// Purpose : N-channel push-button front end. Each channel has a 2-FF synchroniser, a debounce
//           counter, a clean level, and press/release strobes. Define AUTO_REPEAT_EN to add
//           hold-to-repeat strobes.
// Latency : a raw edge sampled at clock k appears on BTN_LEVEL/strobes at clock k+2+DEBOUNCE_CYCLES.
// Backpr. : none. Strobes are single-cycle pulses and are never held or queued.
module button_conditioner #(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int ACTIVE_HIGH     = 1,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_RATE     = 10_000_000
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_BTN-1:0] BTN_RAW,
  output logic [NUM_BTN-1:0] BTN_LEVEL,
  output logic [NUM_BTN-1:0] BTN_PRESS,
  output logic [NUM_BTN-1:0] BTN_RELEASE,
  output logic [NUM_BTN-1:0] BTN_REPEAT,
  output logic               ANY_PRESS
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES);
  localparam logic INVERT = (ACTIVE_HIGH == 0);

  // Reject configurations where a counter would never fire.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : gBadParam
    $error("button_conditioner: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_RATE must be >= 1");
  end

  logic [NUM_BTN-1:0] rawPressed;
  logic [NUM_BTN-1:0] syncA;
  logic [NUM_BTN-1:0] syncB;
  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] toggle;
  logic [NUM_BTN-1:0] pressQ;
  logic [NUM_BTN-1:0] releaseQ;
  logic               anyPressQ;
  logic [CW-1:0]      dbCnt [NUM_BTN];

  // After this XOR, 1 always means "pressed", whatever the pin polarity.
  assign rawPressed = BTN_RAW ^ {NUM_BTN{INVERT}};

  // Two-flop synchroniser. Reset loads the "not pressed" value.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      syncA <= '0;
      syncB <= '0;
    end else begin
      syncA <= rawPressed;
      syncB <= syncA;
    end
  end

  // A channel flips once its counter has held the full count with the input still disagreeing.
  always_comb begin
    toggle = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      toggle[i] = (syncB[i] != level[i]) && (dbCnt[i] == DB_LAST);
    end
  end

  // Debounce counters and the accepted level. Any agreeing cycle restarts the count.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      level <= '0;
      for (int i = 0; i < NUM_BTN; i++) dbCnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (syncB[i] == level[i] || toggle[i]) begin
          dbCnt[i] <= '0;
        end else begin
          dbCnt[i] <= dbCnt[i] + 1'b1;
        end
        if (toggle[i]) level[i] <= ~level[i];
      end
    end
  end

  // Edge strobes are registered next to the level, so all of them change in the same cycle.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pressQ    <= '0;
      releaseQ  <= '0;
      anyPressQ <= 1'b0;
    end else begin
      pressQ    <= toggle & ~level;
      releaseQ  <= toggle & level;
      anyPressQ <= |(toggle & ~level);
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW      = $clog2(RPT_MAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0]      holdCnt [NUM_BTN];
  logic [NUM_BTN-1:0] pastFirst;
  logic [NUM_BTN-1:0] repeatQ;

  // Hold counters restart on press or release. The first repeat waits REPEAT_DELAY cycles and
  // later repeats wait REPEAT_RATE cycles. A toggle cycle never emits a repeat.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pastFirst <= '0;
      repeatQ   <= '0;
      for (int i = 0; i < NUM_BTN; i++) holdCnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        repeatQ[i] <= 1'b0;
        if (toggle[i] || !level[i]) begin
          holdCnt[i]   <= '0;
          pastFirst[i] <= 1'b0;
        end else if (holdCnt[i] == (pastFirst[i] ? RATE_LAST : DELAY_LAST)) begin
          holdCnt[i]   <= '0;
          pastFirst[i] <= 1'b1;
          repeatQ[i]   <= 1'b1;
        end else begin
          holdCnt[i] <= holdCnt[i] + 1'b1;
        end
      end
    end
  end

  assign BTN_REPEAT = repeatQ;
`else
  assign BTN_REPEAT = '0;
`endif

  assign BTN_LEVEL   = level;
  assign BTN_PRESS   = pressQ;
  assign BTN_RELEASE = releaseQ;
  assign ANY_PRESS   = anyPressQ;

endmodule
